// File: rtl/sig_capture_pkg.sv
// sig_capture_pkg: shared FSM state encoding, default sizing constants and the
// pointer-width helper used by the single-shot capture block and its buffer.
package sig_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_e;

    localparam int DEF_D_WIDTH      = 8;
    localparam int DEF_DEPTH        = 64;
    localparam int DEF_AUTO_TIMEOUT = 256;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sig_capture_if.sv
// sig_capture_if: sample input, trigger control, status and readout stream of
// the capture block. The slave modport is the capture block's view.
interface sig_capture_if
    import sig_capture_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
);
    logic               sample_en;
    logic [D_WIDTH-1:0] din1;
    logic [D_WIDTH-1:0] din2;
    logic [D_WIDTH-1:0] trig_level;
    logic               arm;
    logic               rd_ready;
    logic               rd_valid;
    logic [D_WIDTH-1:0] rd_data1;
    logic [D_WIDTH-1:0] rd_data2;
    logic               rd_last;
    logic               armed;
    logic               busy;
    logic               auto_trig;

    modport master (
        output sample_en, din1, din2, trig_level, arm, rd_ready,
        input  rd_valid, rd_data1, rd_data2, rd_last, armed, busy, auto_trig
    );

    modport slave (
        input  sample_en, din1, din2, trig_level, arm, rd_ready,
        output rd_valid, rd_data1, rd_data2, rd_last, armed, busy, auto_trig
    );
endinterface

// File: rtl/sig_capture_ram.sv
// capture_ram: simple dual-port frame buffer, synchronous write and synchronous
// read with read-enable. Contents and read register are deliberately not reset.
module capture_ram
    import sig_capture_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = 2 * DEF_D_WIDTH,
    localparam int AW = ptrWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // rdata_o holds its value while re_i is low, which keeps a stalled beat stable.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/sig_capture.sv
// sig_capture: single-shot two-channel scope capture with rising level trigger and
// valid/ready frame readout. Build option SIG_CAPTURE_AUTO_TRIG_EN adds a forced trigger.
module sig_capture
    import sig_capture_pkg::*;
#(
    parameter int D_WIDTH      = DEF_D_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    sig_capture_if.slave bus
);
    localparam int            PW       = ptrWidth(DEPTH);
    localparam int            RW       = 2 * D_WIDTH;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    cap_state_e         state_q;
    cap_state_e         state_d;
    logic [PW-1:0]      wrPtr_q;
    logic [PW-1:0]      rdPtr_q;
    logic [D_WIDTH-1:0] prev_q;
    logic               prevValid_q;
    logic               rdValid_q;
    logic               rdLast_q;
    logic               armed_q;
    logic               busy_q;

    logic               trigHit;
    logic               autoHit;
    logic               ramWe;
    logic [PW-1:0]      ramWaddr;
    logic               ramRe;
    logic               drainEnd;
    logic [RW-1:0]      ramRdata;

`ifdef SIG_CAPTURE_AUTO_TRIG_EN
    localparam int            TW       = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(AUTO_TIMEOUT);

    logic [TW-1:0] toCnt_q;
    logic          autoTrig_q;
`else
    logic unusedTimeout;
    assign unusedTimeout = (AUTO_TIMEOUT > 0);
`endif

    always_comb begin
        state_d  = state_q;
        trigHit  = 1'b0;
        autoHit  = 1'b0;
        ramWe    = 1'b0;
        ramWaddr = wrPtr_q;
        ramRe    = 1'b0;
        drainEnd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                trigHit = bus.sample_en && prevValid_q &&
                          (prev_q < bus.trig_level) && (bus.din1 >= bus.trig_level);
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
                autoHit = bus.sample_en && !trigHit && (toCnt_q == TO_LIMIT);
`endif
                if (trigHit || autoHit) begin
                    ramWe    = 1'b1;
                    ramWaddr = '0;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                ramWe = bus.sample_en;
                if (bus.sample_en && (wrPtr_q == LAST_PTR)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Fetch ahead whenever the output slot is empty or is being consumed.
                if (rdValid_q && bus.rd_ready && rdLast_q) begin
                    drainEnd = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!rdValid_q || bus.rd_ready) begin
                    ramRe = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            prev_q      <= '0;
            prevValid_q <= 1'b0;
            rdValid_q   <= 1'b0;
            rdLast_q    <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
            toCnt_q     <= '0;
            autoTrig_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= (state_d == ST_ARMED);
            busy_q  <= (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        prevValid_q <= 1'b0;
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
                        toCnt_q     <= '0;
                        autoTrig_q  <= 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (bus.sample_en) begin
                        prev_q      <= bus.din1;
                        prevValid_q <= 1'b1;
                    end
                    if (trigHit || autoHit) begin
                        wrPtr_q <= PW'(1);
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
                        autoTrig_q <= autoHit;
                    end else if (bus.sample_en) begin
                        toCnt_q <= toCnt_q + TW'(1);
`endif
                    end
                end
                ST_CAPTURE: begin
                    if (ramWe) begin
                        wrPtr_q <= wrPtr_q + PW'(1);
                        if (wrPtr_q == LAST_PTR) begin
                            rdPtr_q <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ramRe) begin
                        rdPtr_q   <= rdPtr_q + PW'(1);
                        rdValid_q <= 1'b1;
                        rdLast_q  <= (rdPtr_q == LAST_PTR);
                    end else if (drainEnd) begin
                        rdValid_q <= 1'b0;
                        rdLast_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i ({bus.din1, bus.din2}),
        .re_i    (ramRe),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    // The buffer read register is never reset, so data is masked until a beat is valid.
    assign bus.rd_valid = rdValid_q;
    assign bus.rd_data1 = rdValid_q ? ramRdata[RW-1:D_WIDTH] : '0;
    assign bus.rd_data2 = rdValid_q ? ramRdata[D_WIDTH-1:0] : '0;
    assign bus.rd_last  = rdLast_q;
    assign bus.armed    = armed_q;
    assign bus.busy     = busy_q;
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
    assign bus.auto_trig = autoTrig_q;
`else
    assign bus.auto_trig = 1'b0;
`endif

endmodule

// File: tb/tb_sig_capture.sv
// tb_sig_capture: drives ramp/hold/random sample streams into sig_capture and checks
// each drained frame against a trigger-search model over the recorded sample history.
module tb_sig_capture;

    localparam int DW           = 8;
    localparam int DEPTH        = 64;
    localparam int AUTO_TIMEOUT = 256;
    localparam int K_RAMP       = 0;
    localparam int K_HOLD       = 1;
    localparam int K_RAND       = 2;
    localparam int BUDGET       = 3000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   armQ1[$];
    int   armQ2[$];
    int   beats, firstD1, firstD2, lastD1, lvlR;

    sig_capture_if #(.D_WIDTH(DW)) bus ();

    sig_capture #(
        .D_WIDTH      (DW),
        .DEPTH        (DEPTH),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Frame starts at the first rising crossing after the prev-loading sample,
    // or at sample AUTO_TIMEOUT+1 when the forced trigger is built in.
    function automatic int findTrigger(input int lvl, output bit autoHit);
        int limit;
        autoHit = 1'b0;
        limit   = armQ1.size() - 1;
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
        if (limit > AUTO_TIMEOUT) limit = AUTO_TIMEOUT;
`endif
        for (int k = 1; k <= limit; k++) begin
            if (armQ1[k-1] < lvl && armQ1[k] >= lvl) return k;
        end
`ifdef SIG_CAPTURE_AUTO_TRIG_EN
        if (armQ1.size() > AUTO_TIMEOUT) begin
            autoHit = 1'b1;
            return AUTO_TIMEOUT;
        end
`endif
        return -1;
    endfunction

    function automatic bit readyFor(input int kind, input int cyc);
        if (kind == 0) return 1'b1;
        if (kind == 1) return 1'($urandom_range(0, 1));
        return ((cyc % 16) >= 5) ? 1'(cyc % 2) : 1'b0;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Valid"}, bus.rd_valid, 0);
        checkOutput({tag, "Busy"}, bus.busy, 0);
        checkOutput({tag, "Armed"}, bus.armed, 0);
        checkOutput({tag, "Last"}, bus.rd_last, 0);
        checkOutput({tag, "Auto"}, bus.auto_trig, 0);
    endtask

    task automatic applyStimulus(input int kind, input int start, input int lvl, input int readyKind,
                                 input bit armMid, input int resetAfter,
                                 output int nBeats, output int fD1, output int fD2, output int lD1);
        int s, trig, d1, d2;
        bit en, expReady, lastSent, done, autoExp, armMidDone;
        s = 0; trig = -1; nBeats = 0; fD1 = -1; fD2 = -1; lD1 = -1;
        expReady = 0; lastSent = 0; done = 0; autoExp = 0; armMidDone = 0;
        armQ1.delete();
        armQ2.delete();
        bus.trig_level = DW'(lvl);
        bus.sample_en  = 1'b0;
        bus.rd_ready   = 1'b0;
        bus.arm        = 1'b1;
        tick();
        bus.arm = 1'b0;
        checkOutput("armedAfterArm", bus.armed, 1);
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            if (resetAfter > 0 && nBeats == resetAfter) begin
                rst = 1'b0;
                #1;
                checkOutput("rstMidValid", bus.rd_valid, 0);
                checkOutput("rstMidBusy", bus.busy, 0);
                checkOutput("rstMidArmed", bus.armed, 0);
                bus.sample_en = 1'b0;
                bus.rd_ready  = 1'b0;
                tick();
                tick();
                rst = 1'b1;
                tick();
                return;
            end
            if (lastSent) begin
                checkOutput("validAfterLast", bus.rd_valid, 0);
                checkOutput("busyAfterLast", bus.busy, 0);
                checkOutput("armedAfterLast", bus.armed, 0);
                done = 1'b1;
            end else begin
                bus.rd_ready = readyFor(readyKind, cyc);
                if (bus.rd_valid) begin
                    if (!expReady) begin
                        expReady = 1'b1;
                        trig = findTrigger(lvl, autoExp);
                        checkOutput("trigFound", 32'(trig >= 0), 1);
                        checkOutput("autoTrig", bus.auto_trig, 32'(autoExp));
                    end
                    if (trig >= 0 && trig + nBeats < armQ1.size()) begin
                        checkOutput("rdData1", bus.rd_data1, armQ1[trig + nBeats]);
                        checkOutput("rdData2", bus.rd_data2, armQ2[trig + nBeats]);
                        checkOutput("rdLast", bus.rd_last, 32'(nBeats == DEPTH - 1));
                    end else if (trig >= 0) begin
                        checkOutput("beatInFrame", 0, 1);
                    end
                    if (bus.rd_ready) begin
                        if (nBeats == 0) begin
                            fD1 = bus.rd_data1;
                            fD2 = bus.rd_data2;
                        end
                        lD1 = bus.rd_data1;
                        nBeats++;
                        lastSent = (nBeats == DEPTH);
                    end
                end
                en = 1'b1;
                case (kind)
                    K_RAMP:  d1 = (start + s) & 255;
                    K_HOLD:  d1 = (s < 20) ? 200 : ((s - 20) & 255);
                    default: begin
                        en = ($urandom_range(0, 3) != 0);
                        d1 = $urandom_range(0, 255);
                    end
                endcase
                d2 = (kind == K_RAND) ? $urandom_range(0, 255) : ((d1 + 64) & 255);
                bus.sample_en = en;
                bus.din1      = DW'(d1);
                bus.din2      = DW'(d2);
                if (en) begin
                    armQ1.push_back(d1);
                    armQ2.push_back(d2);
                    s++;
                end
                bus.arm = armMid && !armMidDone && bus.busy && !bus.rd_valid;
                if (bus.arm) armMidDone = 1'b1;
                tick();
                bus.arm = 1'b0;
            end
        end
        checkOutput("frameDone", 32'(done), 1);
        bus.sample_en = 1'b0;
        bus.rd_ready  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.sample_en = 1'b0;
        bus.din1 = '0;
        bus.din2 = '0;
        bus.trig_level = '0;
        bus.arm = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
        checkIdleOutputs("reset");
        checkOutput("resetData1", bus.rd_data1, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        $display("[TB] ramp trigger at 100");
        applyStimulus(K_RAMP, 0, 100, 0, 1'b0, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("rampBeats", beats, 64);
        checkOutput("rampFirstD1", firstD1, 100);
        checkOutput("rampFirstD2", firstD2, 164);
        checkOutput("rampLastD1", lastD1, 163);

        $display("[TB] hold 200 then ramp");
        applyStimulus(K_HOLD, 0, 100, 0, 1'b0, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("holdFirstD1", firstD1, 100);

        $display("[TB] backpressure");
        applyStimulus(K_RAMP, 0, 100, 2, 1'b0, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("bpBeats", beats, 64);
        checkOutput("bpFirstD1", firstD1, 100);
        checkOutput("bpLastD1", lastD1, 163);

        $display("[TB] wrap with arm during capture");
        applyStimulus(K_RAMP, 250, 2, 1, 1'b1, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("wrapBeats", beats, 64);
        checkOutput("wrapFirstD1", firstD1, 2);

        $display("[TB] reset during drain");
        applyStimulus(K_RAMP, 0, 100, 0, 1'b0, 10, beats, firstD1, firstD2, lastD1);
        checkIdleOutputs("postReset");
        applyStimulus(K_RAMP, 0, 100, 1, 1'b0, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("freshBeats", beats, 64);
        checkOutput("freshFirstD1", firstD1, 100);

        $display("[TB] random frames");
        for (int r = 0; r < 4; r++) begin
            lvlR = $urandom_range(16, 240);
            applyStimulus(K_RAND, 0, lvlR, 1, 1'b0, 0, beats, firstD1, firstD2, lastD1);
            checkOutput("randBeats", beats, 64);
        end

`ifdef SIG_CAPTURE_AUTO_TRIG_EN
        $display("[TB] level 0 forced trigger");
        applyStimulus(K_RAND, 0, 0, 0, 1'b0, 0, beats, firstD1, firstD2, lastD1);
        checkOutput("autoBeats", beats, 64);
`else
        $display("[TB] level 0 never triggers");
        bus.trig_level = '0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bus.sample_en = 1'b1;
            bus.din1 = DW'($urandom_range(0, 255));
            bus.din2 = DW'($urandom_range(0, 255));
            tick();
            if ((i % 250) == 249) begin
                checkOutput("lvl0Armed", bus.armed, 1);
                checkOutput("lvl0Busy", bus.busy, 0);
            end
        end
        bus.sample_en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkIdleOutputs("lvl0Reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
